// File: rtl/miner_dispatcher_if.sv
// ----------------------------------------------------------------------------
// miner_dispatcher_if
// Bundles the job intake, miner fan-out/fan-in and result handshake of the
// miner dispatcher.
//   slave  modport : dispatcher side (drives *_O, samples *_I)
//   master modport : job source / miner array / result sink side
// Signal summary:
//   JobVld_I/JobRdy_O/JobNonce_I/JobAbort_I   job intake and cancel
//   MinerUpdate_O/MinerNonce_O/MinerClear_O   per-miner load and clear
//   MinerVld_I/MinerNonce_I/MinerHash_I       per-miner results, miner 0 in LSBs
//   ResVld_O/ResRdy_I/ResNonce_O/ResHash_O/ResMiner_O  winning result
//   Busy_O/TimedOut_O                         status
// ----------------------------------------------------------------------------
interface miner_dispatcher_if #(
   parameter int N_MINERS       = 4,
   parameter int NONCE_BYTE_LEN = 24
);
   localparam int NW = NONCE_BYTE_LEN * 8;
   localparam int IW = (N_MINERS > 1) ? $clog2(N_MINERS) : 1;

   logic                     JobVld_I;
   logic                     JobRdy_O;
   logic [NW-1:0]            JobNonce_I;
   logic                     JobAbort_I;
   logic [N_MINERS-1:0]      MinerUpdate_O;
   logic [NW-1:0]            MinerNonce_O;
   logic [N_MINERS-1:0]      MinerClear_O;
   logic [N_MINERS-1:0]      MinerVld_I;
   logic [N_MINERS*NW-1:0]   MinerNonce_I;
   logic [N_MINERS*256-1:0]  MinerHash_I;
   logic                     ResVld_O;
   logic                     ResRdy_I;
   logic [NW-1:0]            ResNonce_O;
   logic [255:0]             ResHash_O;
   logic [IW-1:0]            ResMiner_O;
   logic                     Busy_O;
   logic                     TimedOut_O;

   modport slave (
      input  JobVld_I, JobNonce_I, JobAbort_I,
      input  MinerVld_I, MinerNonce_I, MinerHash_I, ResRdy_I,
      output JobRdy_O, MinerUpdate_O, MinerNonce_O, MinerClear_O,
      output ResVld_O, ResNonce_O, ResHash_O, ResMiner_O, Busy_O, TimedOut_O
   );

   modport master (
      output JobVld_I, JobNonce_I, JobAbort_I,
      output MinerVld_I, MinerNonce_I, MinerHash_I, ResRdy_I,
      input  JobRdy_O, MinerUpdate_O, MinerNonce_O, MinerClear_O,
      input  ResVld_O, ResNonce_O, ResHash_O, ResMiner_O, Busy_O, TimedOut_O
   );
endinterface

// File: rtl/miner_dispatcher.sv
// ----------------------------------------------------------------------------
// miner_dispatcher
// Job-level controller in front of N_MINERS miners. Accepts one job, loads each
// miner serially with a disjoint start nonce (base + i<<STRIDE_LOG2), watches
// all miners for a hit, reports the first hit through a round-robin arbiter,
// cancels on abort or timeout, and clears every miner before the next job.
// Ports:
//   Clk    clock
//   Rst_n  asynchronous active-low reset (aborts any job immediately)
//   bus    miner_dispatcher_if.slave: job intake, miner fan-out/fan-in,
//          result handshake, Busy/TimedOut status
// All outputs on bus are driven straight from registers.
// ----------------------------------------------------------------------------
module miner_dispatcher #(
   parameter int N_MINERS       = 4,
   parameter int NONCE_BYTE_LEN = 24,
   parameter int STRIDE_LOG2    = 32,
   parameter int TIMEOUT_CYCLES = 2**24
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   miner_dispatcher_if.slave     bus
);
   localparam int NW = NONCE_BYTE_LEN * 8;
   localparam int IW = (N_MINERS > 1) ? $clog2(N_MINERS) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [N_MINERS-1:0] ALL_MINERS = {N_MINERS{1'b1}};
   localparam logic [IW-1:0]       LAST_IDX   = IW'(N_MINERS - 1);
   localparam logic [TW-1:0]       LAST_TMO   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RUN    = 3'd2,
      ST_REPORT = 3'd3,
      ST_FLUSH  = 3'd4
   } state_t;

   state_t                state_q;
   logic [NW-1:0]         base_q;
   logic [IW-1:0]         load_idx_q;
   logic [IW-1:0]         rr_ptr_q;
   logic [TW-1:0]         tmo_q;
   logic                  job_rdy_q;
   logic [N_MINERS-1:0]   upd_q;
   logic [NW-1:0]         mnonce_q;
   logic [N_MINERS-1:0]   clear_q;
   logic                  res_vld_q;
   logic [NW-1:0]         res_nonce_q;
   logic [255:0]          res_hash_q;
   logic [IW-1:0]         res_miner_q;
   logic                  busy_q;
   logic                  timed_out_q;

   logic                  hit_s;
   logic [IW-1:0]         win_idx_s;
   logic [IW:0]           cand_s;
   logic [IW-1:0]         nxt_idx_s;
   logic [NW-1:0]         mnonce_d;
   logic [IW-1:0]         rr_ptr_d;

   // Round-robin pick: first Vld bit at or above rr_ptr, wrapping past the top.
   always_comb begin
      hit_s     = 1'b0;
      win_idx_s = '0;
      cand_s    = '0;
      for (int k = 0; k < N_MINERS; k++) begin
         cand_s = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (cand_s >= (IW+1)'(N_MINERS)) begin
            cand_s = cand_s - (IW+1)'(N_MINERS);
         end else begin
            cand_s = cand_s;
         end
         if (!hit_s && bus.MinerVld_I[cand_s[IW-1:0]]) begin
            hit_s     = 1'b1;
            win_idx_s = cand_s[IW-1:0];
         end else begin
            hit_s     = hit_s;
         end
      end
   end

   // Next load slot, its start nonce (wraps mod 2^NW) and the pointer after a hit.
   always_comb begin
      nxt_idx_s = load_idx_q + IW'(1);
      mnonce_d  = base_q + (NW'(nxt_idx_s) << STRIDE_LOG2);
      if (win_idx_s == LAST_IDX) begin
         rr_ptr_d = '0;
      end else begin
         rr_ptr_d = win_idx_s + IW'(1);
      end
   end

   // Job FSM; every output is registered and changes together with the state.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         load_idx_q  <= '0;
         rr_ptr_q    <= '0;
         tmo_q       <= '0;
         job_rdy_q   <= 1'b1;
         upd_q       <= '0;
         mnonce_q    <= '0;
         clear_q     <= '0;
         res_vld_q   <= 1'b0;
         res_nonce_q <= '0;
         res_hash_q  <= '0;
         res_miner_q <= '0;
         busy_q      <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.JobVld_I) begin
                  base_q     <= bus.JobNonce_I;
                  load_idx_q <= '0;
                  upd_q      <= N_MINERS'(1);
                  mnonce_q   <= bus.JobNonce_I;
                  job_rdy_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               // The Update currently on the bus completes; later slots are skipped on abort.
               if (bus.JobAbort_I) begin
                  upd_q    <= '0;
                  mnonce_q <= '0;
                  clear_q  <= ALL_MINERS;
                  state_q  <= ST_FLUSH;
               end else if (load_idx_q == LAST_IDX) begin
                  upd_q    <= '0;
                  mnonce_q <= '0;
                  tmo_q    <= '0;
                  state_q  <= ST_RUN;
               end else begin
                  load_idx_q <= nxt_idx_s;
                  upd_q      <= N_MINERS'(1) << nxt_idx_s;
                  mnonce_q   <= mnonce_d;
               end
            end
            ST_RUN: begin
               // A hit outranks abort, which outranks timeout.
               if (hit_s) begin
                  res_vld_q   <= 1'b1;
                  res_nonce_q <= bus.MinerNonce_I[int'(win_idx_s)*NW +: NW];
                  res_hash_q  <= bus.MinerHash_I[int'(win_idx_s)*256 +: 256];
                  res_miner_q <= win_idx_s;
                  rr_ptr_q    <= rr_ptr_d;
                  state_q     <= ST_REPORT;
               end else if (bus.JobAbort_I) begin
                  clear_q <= ALL_MINERS;
                  state_q <= ST_FLUSH;
               end else if (tmo_q == LAST_TMO) begin
                  timed_out_q <= 1'b1;
                  clear_q     <= ALL_MINERS;
                  state_q     <= ST_FLUSH;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            ST_REPORT: begin
               // Abort is deliberately not looked at: the result must be handed off.
               if (bus.ResRdy_I) begin
                  res_vld_q <= 1'b0;
                  clear_q   <= ALL_MINERS;
                  state_q   <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               clear_q     <= '0;
               timed_out_q <= 1'b0;
               res_vld_q   <= 1'b0;
               job_rdy_q   <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: begin
               upd_q       <= '0;
               mnonce_q    <= '0;
               clear_q     <= '0;
               res_vld_q   <= 1'b0;
               timed_out_q <= 1'b0;
               job_rdy_q   <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.JobRdy_O      = job_rdy_q;
   assign bus.MinerUpdate_O = upd_q;
   assign bus.MinerNonce_O  = mnonce_q;
   assign bus.MinerClear_O  = clear_q;
   assign bus.ResVld_O      = res_vld_q;
   assign bus.ResNonce_O    = res_nonce_q;
   assign bus.ResHash_O     = res_hash_q;
   assign bus.ResMiner_O    = res_miner_q;
   assign bus.Busy_O        = busy_q;
   assign bus.TimedOut_O    = timed_out_q;

endmodule

// File: tb/tb_miner_dispatcher.sv
module tb_miner_dispatcher;
   localparam int N   = 4;
   localparam int NBL = 24;
   localparam int NW  = NBL * 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   miner_dispatcher_if #(.N_MINERS(N), .NONCE_BYTE_LEN(NBL)) bus ();

   miner_dispatcher #(
      .N_MINERS(N), .NONCE_BYTE_LEN(NBL), .STRIDE_LOG2(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .Clk(clk),
      .Rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [NW-1:0] nonce);
      bus.JobNonce_I = nonce;
      bus.JobVld_I   = 1'b1;
      tick();
      bus.JobVld_I   = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      checks++; if (bus.JobRdy_O !== 1'b1) begin errors++; $display("FAIL reset_jobrdy got %0h exp 1", bus.JobRdy_O); end
      checks++; if (bus.ResVld_O !== 1'b0) begin errors++; $display("FAIL reset_resvld got %0h exp 0", bus.ResVld_O); end
      checks++; if (bus.Busy_O !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", bus.Busy_O); end
      checks++; if (bus.MinerUpdate_O !== 4'b0000 || bus.MinerClear_O !== 4'b0000) begin errors++; $display("FAIL reset_miner_ctl got upd %b clr %b exp 0000", bus.MinerUpdate_O, bus.MinerClear_O); end
      checks++; if (bus.TimedOut_O !== 1'b0 || bus.ResMiner_O !== 2'd0 || bus.MinerNonce_O !== '0) begin errors++; $display("FAIL reset_misc got tmo %0h miner %0d nonce %0h exp 0", bus.TimedOut_O, bus.ResMiner_O, bus.MinerNonce_O); end
   endtask

   task automatic test_load_and_report();
      logic [NW-1:0] exp_n [4];
      exp_n[0] = 192'h10;
      exp_n[1] = 192'h1_0000_0010;
      exp_n[2] = 192'h2_0000_0010;
      exp_n[3] = 192'h3_0000_0010;
      start_job(192'h10);
      for (int i = 0; i < N; i++) begin
         checks++; if (bus.MinerUpdate_O !== 4'(1 << i)) begin errors++; $display("FAIL load_update%0d got %b exp %b", i, bus.MinerUpdate_O, 4'(1 << i)); end
         checks++; if (bus.MinerNonce_O !== exp_n[i]) begin errors++; $display("FAIL load_nonce%0d got %0h exp %0h", i, bus.MinerNonce_O, exp_n[i]); end
         checks++; if (bus.JobRdy_O !== 1'b0 || bus.MinerClear_O !== 4'b0000) begin errors++; $display("FAIL load_rdy_clr%0d got rdy %0h clr %b exp 0 0000", i, bus.JobRdy_O, bus.MinerClear_O); end
         tick();
      end
      checks++; if (bus.MinerUpdate_O !== 4'b0000 || bus.MinerNonce_O !== '0 || bus.Busy_O !== 1'b1) begin errors++; $display("FAIL run_entry got upd %b nonce %0h busy %0h exp 0000 0 1", bus.MinerUpdate_O, bus.MinerNonce_O, bus.Busy_O); end
      bus.MinerNonce_I[2*NW +: NW]   = 192'hABC;
      bus.MinerHash_I[2*256 +: 256]  = 256'hDEAD_BEEF_0123;
      bus.MinerVld_I = 4'b0100;
      tick();
      for (int c = 0; c < 5; c++) begin
         bus.JobAbort_I = (c == 2) ? 1'b1 : 1'b0;
         checks++; if (bus.ResVld_O !== 1'b1 || bus.ResMiner_O !== 2'd2) begin errors++; $display("FAIL report_hold%0d got vld %0h miner %0d exp 1 2", c, bus.ResVld_O, bus.ResMiner_O); end
         checks++; if (bus.ResNonce_O !== 192'hABC || bus.ResHash_O !== 256'hDEAD_BEEF_0123) begin errors++; $display("FAIL report_data%0d got nonce %0h hash %0h exp abc deadbeef0123", c, bus.ResNonce_O, bus.ResHash_O); end
         tick();
      end
      bus.JobAbort_I = 1'b0;
      checks++; if (bus.ResVld_O !== 1'b1 || bus.MinerClear_O !== 4'b0000) begin errors++; $display("FAIL report_abort_ignored got vld %0h clr %b exp 1 0000", bus.ResVld_O, bus.MinerClear_O); end
      bus.ResRdy_I = 1'b1;
      tick();
      bus.ResRdy_I = 1'b0;
      checks++; if (bus.MinerClear_O !== 4'b1111 || bus.ResVld_O !== 1'b0 || bus.JobRdy_O !== 1'b0) begin errors++; $display("FAIL flush got clr %b vld %0h rdy %0h exp 1111 0 0", bus.MinerClear_O, bus.ResVld_O, bus.JobRdy_O); end
      bus.MinerVld_I = 4'b0000;
      tick();
      checks++; if (bus.MinerClear_O !== 4'b0000 || bus.JobRdy_O !== 1'b1 || bus.Busy_O !== 1'b0) begin errors++; $display("FAIL back_idle got clr %b rdy %0h busy %0h exp 0000 1 0", bus.MinerClear_O, bus.JobRdy_O, bus.Busy_O); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_m [2];
      exp_m[0] = 2'd1;
      exp_m[1] = 2'd3;
      apply_reset();
      for (int j = 0; j < 2; j++) begin
         start_job(192'h100);
         repeat (N) tick();
         bus.MinerVld_I = 4'b1010;
         tick();
         checks++; if (bus.ResVld_O !== 1'b1 || bus.ResMiner_O !== exp_m[j]) begin errors++; $display("FAIL rr_job%0d got vld %0h miner %0d exp 1 %0d", j, bus.ResVld_O, bus.ResMiner_O, exp_m[j]); end
         bus.ResRdy_I = 1'b1;
         tick();
         bus.ResRdy_I = 1'b0;
         bus.MinerVld_I = 4'b0000;
         tick();
      end
   endtask

   task automatic test_timeout();
      start_job(192'h55);
      repeat (N) tick();
      for (int k = 1; k < 8; k++) begin
         tick();
         checks++; if (bus.TimedOut_O !== 1'b0 || bus.MinerClear_O !== 4'b0000) begin errors++; $display("FAIL tmo_early%0d got tmo %0h clr %b exp 0 0000", k, bus.TimedOut_O, bus.MinerClear_O); end
      end
      tick();
      checks++; if (bus.TimedOut_O !== 1'b1 || bus.MinerClear_O !== 4'b1111 || bus.ResVld_O !== 1'b0) begin errors++; $display("FAIL tmo_fire got tmo %0h clr %b vld %0h exp 1 1111 0", bus.TimedOut_O, bus.MinerClear_O, bus.ResVld_O); end
      tick();
      checks++; if (bus.TimedOut_O !== 1'b0 || bus.JobRdy_O !== 1'b1) begin errors++; $display("FAIL tmo_after got tmo %0h rdy %0h exp 0 1", bus.TimedOut_O, bus.JobRdy_O); end
   endtask

   task automatic test_abort_load();
      start_job(192'h20);
      tick();
      checks++; if (bus.MinerUpdate_O !== 4'b0010) begin errors++; $display("FAIL abort_second_update got %b exp 0010", bus.MinerUpdate_O); end
      bus.JobAbort_I = 1'b1;
      tick();
      bus.JobAbort_I = 1'b0;
      checks++; if (bus.MinerUpdate_O !== 4'b0000 || bus.MinerClear_O !== 4'b1111) begin errors++; $display("FAIL abort_flush got upd %b clr %b exp 0000 1111", bus.MinerUpdate_O, bus.MinerClear_O); end
      tick();
      checks++; if (bus.MinerUpdate_O !== 4'b0000 || bus.JobRdy_O !== 1'b1 || bus.MinerClear_O !== 4'b0000) begin errors++; $display("FAIL abort_idle got upd %b rdy %0h clr %b exp 0000 1 0000", bus.MinerUpdate_O, bus.JobRdy_O, bus.MinerClear_O); end
   endtask

   task automatic test_abort_vs_vld();
      start_job(192'h30);
      repeat (N) tick();
      bus.MinerNonce_I[0 +: NW] = 192'h777;
      bus.MinerVld_I = 4'b0001;
      bus.JobAbort_I = 1'b1;
      tick();
      bus.JobAbort_I = 1'b0;
      checks++; if (bus.ResVld_O !== 1'b1 || bus.ResMiner_O !== 2'd0 || bus.ResNonce_O !== 192'h777) begin errors++; $display("FAIL abort_vld got vld %0h miner %0d nonce %0h exp 1 0 777", bus.ResVld_O, bus.ResMiner_O, bus.ResNonce_O); end
      bus.ResRdy_I = 1'b1;
      tick();
      bus.ResRdy_I = 1'b0;
      bus.MinerVld_I = 4'b0000;
      tick();
   endtask

   task automatic test_wrap_and_reset_in_report();
      logic [NW-1:0] exp_n [4];
      exp_n[0] = {NW{1'b1}};
      exp_n[1] = 192'hFFFF_FFFF;
      exp_n[2] = 192'h1_FFFF_FFFF;
      exp_n[3] = 192'h2_FFFF_FFFF;
      start_job({NW{1'b1}});
      for (int i = 0; i < N; i++) begin
         checks++; if (bus.MinerNonce_O !== exp_n[i]) begin errors++; $display("FAIL wrap_nonce%0d got %0h exp %0h", i, bus.MinerNonce_O, exp_n[i]); end
         tick();
      end
      bus.MinerVld_I = 4'b1000;
      tick();
      checks++; if (bus.ResVld_O !== 1'b1) begin errors++; $display("FAIL rst_pre_report got %0h exp 1", bus.ResVld_O); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.ResVld_O !== 1'b0 || bus.MinerClear_O !== 4'b0000 || bus.JobRdy_O !== 1'b1 || bus.Busy_O !== 1'b0) begin errors++; $display("FAIL rst_in_report got vld %0h clr %b rdy %0h busy %0h exp 0 0000 1 0", bus.ResVld_O, bus.MinerClear_O, bus.JobRdy_O, bus.Busy_O); end
      bus.MinerVld_I = 4'b0000;
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (bus.JobRdy_O !== 1'b1 || bus.ResVld_O !== 1'b0) begin errors++; $display("FAIL rst_release got rdy %0h vld %0h exp 1 0", bus.JobRdy_O, bus.ResVld_O); end
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      rst_n            = 1'b0;
      bus.JobVld_I     = 1'b0;
      bus.JobNonce_I   = '0;
      bus.JobAbort_I   = 1'b0;
      bus.MinerVld_I   = '0;
      bus.MinerNonce_I = '0;
      bus.MinerHash_I  = '0;
      bus.ResRdy_I     = 1'b0;
      repeat (3) tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_load_and_report();
      test_round_robin();
      test_timeout();
      test_abort_load();
      test_abort_vs_vld();
      test_wrap_and_reset_in_report();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
